// File: rtl/rect_fill_ctrl_if.sv
// Command and pixel-write handshake bundle
// for the rectangle fill controller.
interface rect_fill_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x0;
  logic [9:0]  cmd_y0;
  logic [9:0]  cmd_x1;
  logic [9:0]  cmd_y1;
  logic [23:0] cmd_color;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_x;
  logic [9:0]  wr_y;
  logic [23:0] wr_pixel;

  modport master (
    output cmd_valid,
    input  cmd_ready,
    output cmd_x0,
    output cmd_y0,
    output cmd_x1,
    output cmd_y1,
    output cmd_color,
    input  wr_valid,
    output wr_ready,
    input  wr_x,
    input  wr_y,
    input  wr_pixel
  );

  modport slave (
    input  cmd_valid,
    output cmd_ready,
    input  cmd_x0,
    input  cmd_y0,
    input  cmd_x1,
    input  cmd_y1,
    input  cmd_color,
    output wr_valid,
    input  wr_ready,
    output wr_x,
    output wr_y,
    output wr_pixel
  );
endinterface

// File: rtl/rect_fill_ctrl.sv
// Rectangle fill controller: walks a checked
// rectangle row-major and emits pixel writes.
module rect_fill_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  rect_fill_ctrl_if.slave bus,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [18:0] pix_count
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    FILL,
    FINISH
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_cmd_ready;
  logic        r_wr_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [9:0]  r_x0;
  logic [9:0]  r_y0;
  logic [9:0]  r_x1;
  logic [9:0]  r_y1;
  logic [23:0] r_color;
  logic [9:0]  r_wr_x;
  logic [9:0]  r_wr_y;
  logic [23:0] r_wr_pixel;
  logic [18:0] r_pix_count;

  logic w_accept;
  logic w_bad;
  logic w_hs;
  logic w_last;
  logic w_eol;

  assign w_accept = (r_state == IDLE)
                  & bus.cmd_valid
                  & r_cmd_ready;
  assign w_bad = (r_x0 > r_x1)
               | (r_y0 > r_y1)
               | (int'(r_x1) >= H_ACTIVE)
               | (int'(r_y1) >= V_ACTIVE);
  assign w_hs   = r_wr_valid & bus.wr_ready;
  assign w_eol  = (r_wr_x == r_x1);
  assign w_last = w_eol & (r_wr_y == r_y1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = CHECK;
      end
      CHECK: begin
        w_next = w_bad ? IDLE : FILL;
      end
      FILL: begin
        // abort wins over a final handshake
        if (abort)
          w_next = IDLE;
        else if (w_hs && w_last)
          w_next = FINISH;
      end
      FINISH: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_color     <= '0;
      r_wr_x      <= '0;
      r_wr_y      <= '0;
      r_wr_pixel  <= '0;
      r_pix_count <= '0;
    end else begin
      r_state     <= w_next;
      r_cmd_ready <= (w_next == IDLE);
      r_busy      <= (w_next != IDLE);
      r_done      <= (w_next == FINISH);
      r_wr_valid  <= (w_next == FILL);
      r_err       <= (r_state == CHECK)
                   & w_bad;
      if (w_accept) begin
        r_x0        <= bus.cmd_x0;
        r_y0        <= bus.cmd_y0;
        r_x1        <= bus.cmd_x1;
        r_y1        <= bus.cmd_y1;
        r_color     <= bus.cmd_color;
        r_pix_count <= '0;
      end
      if (r_state == CHECK && !w_bad) begin
        r_wr_x     <= r_x0;
        r_wr_y     <= r_y0;
        r_wr_pixel <= r_color;
      end
      if (r_state == FILL && w_hs) begin
        r_pix_count <= r_pix_count + 19'd1;
        if (!w_last) begin
          if (w_eol) begin
            r_wr_x <= r_x0;
            r_wr_y <= r_wr_y + 10'd1;
          end else begin
            r_wr_x <= r_wr_x + 10'd1;
          end
        end
      end
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.wr_valid  = r_wr_valid;
  assign bus.wr_x      = r_wr_x;
  assign bus.wr_y      = r_wr_y;
  assign bus.wr_pixel  = r_wr_pixel;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign pix_count     = r_pix_count;

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Directed self-checking bench for
// rect_fill_ctrl.
module tb_rect_fill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;
  logic [18:0] pix_count;

  int n_pass;
  int n_total;

  rect_fill_ctrl_if bus();

  rect_fill_ctrl #(
    .H_ACTIVE(640),
    .V_ACTIVE(480)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pix_count (pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(
    input int x0, input int y0,
    input int x1, input int y1,
    input logic [23:0] c
  );
    n_total++;
    if (bus.cmd_ready !== 1'b1)
      $display("FAIL cmd_ready_pre: got %b want 1",
               bus.cmd_ready);
    else n_pass++;
    bus.cmd_valid = 1'b1;
    bus.cmd_x0    = 10'(x0);
    bus.cmd_y0    = 10'(y0);
    bus.cmd_x1    = 10'(x1);
    bus.cmd_y1    = 10'(y1);
    bus.cmd_color = c;
    tick();
    bus.cmd_valid = 1'b0;
    n_total++;
    if ({busy, bus.cmd_ready, bus.wr_valid}
        !== 3'b100)
      $display("FAIL check_state: got %b want 100",
               {busy, bus.cmd_ready, bus.wr_valid});
    else n_pass++;
  endtask

  // at first FILL cycle with wr_ready=1
  task automatic run_fill(
    input int x0, input int y0,
    input int x1, input int y1,
    input logic [23:0] c
  );
    logic [44:0] got;
    logic [44:0] exp;
    int n;
    n = 0;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        got = {bus.wr_valid, bus.wr_x,
               bus.wr_y, bus.wr_pixel};
        exp = {1'b1, 10'(x), 10'(y), c};
        n_total++;
        if (got !== exp)
          $display("FAIL pixel%0d: got %h want %h",
                   n, got, exp);
        else n_pass++;
        n++;
        tick();
      end
    end
    n_total++;
    if ({done, bus.wr_valid, busy}
        !== 3'b101)
      $display("FAIL finish: got %b want 101",
               {done, bus.wr_valid, busy});
    else n_pass++;
    n_total++;
    if (pix_count !== 19'(n))
      $display("FAIL pix_count: got %0d want %0d",
               pix_count, n);
    else n_pass++;
    tick();
    n_total++;
    if ({done, bus.cmd_ready, busy}
        !== 3'b010)
      $display("FAIL idle_after: got %b want 010",
               {done, bus.cmd_ready, busy});
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    abort         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_color = '0;
    bus.wr_ready  = 1'b1;
    tick();
    tick();
    n_total++;
    if ({bus.cmd_ready, bus.wr_valid, busy,
         done, err} !== 5'b0)
      $display("FAIL rst_flags: got %b want 00000",
               {bus.cmd_ready, bus.wr_valid,
                busy, done, err});
    else n_pass++;
    n_total++;
    if ({bus.wr_x, bus.wr_y, bus.wr_pixel,
         pix_count} !== 63'b0)
      $display("FAIL rst_data: got %h want 0",
               {bus.wr_x, bus.wr_y,
                bus.wr_pixel, pix_count});
    else n_pass++;
    #2 rst_n = 1'b1;
    #1;
    n_total++;
    if (bus.cmd_ready !== 1'b0)
      $display("FAIL rdy_before_edge: got %b want 0",
               bus.cmd_ready);
    else n_pass++;
    tick();
    n_total++;
    if (bus.cmd_ready !== 1'b1)
      $display("FAIL rdy_after_edge: got %b want 1",
               bus.cmd_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    bus.wr_ready = 1'b1;
    send_cmd(2, 3, 4, 4, 24'hFF0000);
    tick();
    run_fill(2, 3, 4, 4, 24'hFF0000);
  endtask

  task automatic test_corner();
    bus.wr_ready = 1'b1;
    send_cmd(636, 478, 639, 479, 24'h00FF00);
    tick();
    run_fill(636, 478, 639, 479, 24'h00FF00);
  endtask

  task automatic reject(
    input int x0, input int y0,
    input int x1, input int y1
  );
    send_cmd(x0, y0, x1, y1, 24'hABCDEF);
    n_total++;
    if (err !== 1'b0)
      $display("FAIL err_early: got %b want 0", err);
    else n_pass++;
    tick();
    n_total++;
    if ({err, bus.wr_valid, bus.cmd_ready, busy}
        !== 4'b1010)
      $display("FAIL err_pulse: got %b want 1010",
               {err, bus.wr_valid,
                bus.cmd_ready, busy});
    else n_pass++;
    n_total++;
    if (pix_count !== 19'd0)
      $display("FAIL err_count: got %0d want 0",
               pix_count);
    else n_pass++;
    tick();
    n_total++;
    if ({err, bus.wr_valid} !== 2'b00)
      $display("FAIL err_width: got %b want 00",
               {err, bus.wr_valid});
    else n_pass++;
  endtask

  task automatic test_reject();
    reject(5, 0, 4, 0);
    reject(0, 0, 640, 0);
    reject(0, 0, 0, 480);
    reject(0, 7, 0, 6);
  endtask

  task automatic test_stall();
    logic rdy [5];
    int   ex  [5];
    rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ex  = '{10, 10, 11, 11, 11};
    send_cmd(10, 10, 11, 10, 24'h0000FF);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.wr_ready = rdy[i];
      n_total++;
      if ({bus.wr_valid, bus.wr_x, bus.wr_y,
           bus.wr_pixel} !==
          {1'b1, 10'(ex[i]), 10'd10, 24'h0000FF})
        $display("FAIL stall%0d: got %b/%0d/%0d want 1/%0d/10",
                 i, bus.wr_valid, bus.wr_x,
                 bus.wr_y, ex[i]);
      else n_pass++;
      tick();
    end
    bus.wr_ready = 1'b1;
    n_total++;
    if ({done, bus.wr_valid, pix_count} !==
        {1'b1, 1'b0, 19'd2})
      $display("FAIL stall_done: got %b/%b/%0d want 1/0/2",
               done, bus.wr_valid, pix_count);
    else n_pass++;
    tick();
  endtask

  task automatic test_abort();
    bus.wr_ready = 1'b1;
    send_cmd(0, 0, 9, 0, 24'h777777);
    tick();
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if ({bus.wr_valid, bus.wr_x} !==
          {1'b1, 10'(k)})
        $display("FAIL abort_x%0d: got %b/%0d want 1/%0d",
                 k, bus.wr_valid, bus.wr_x, k);
      else n_pass++;
      if (k == 3) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    n_total++;
    if ({bus.wr_valid, done, err,
         bus.cmd_ready, busy} !== 5'b00010)
      $display("FAIL abort_state: got %b want 00010",
               {bus.wr_valid, done, err,
                bus.cmd_ready, busy});
    else n_pass++;
    n_total++;
    if (pix_count !== 19'd4)
      $display("FAIL abort_count: got %0d want 4",
               pix_count);
    else n_pass++;
    tick();
    n_total++;
    if ({done, bus.wr_valid} !== 2'b00)
      $display("FAIL abort_nodone: got %b want 00",
               {done, bus.wr_valid});
    else n_pass++;
    // abort held through CHECK has no effect
    send_cmd(20, 5, 21, 5, 24'h0A0B0C);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_fill(20, 5, 21, 5, 24'h0A0B0C);
  endtask

  task automatic test_back_to_back();
    bus.wr_ready = 1'b1;
    send_cmd(1, 1, 1, 1, 24'h111111);
    bus.cmd_valid = 1'b1;
    bus.cmd_x0    = 10'd3;
    bus.cmd_y0    = 10'd2;
    bus.cmd_x1    = 10'd3;
    bus.cmd_y1    = 10'd2;
    bus.cmd_color = 24'h123456;
    tick();
    n_total++;
    if ({bus.wr_x, bus.wr_y, bus.wr_pixel} !==
        {10'd1, 10'd1, 24'h111111})
      $display("FAIL b2b_first: got %0d/%0d/%h want 1/1/111111",
               bus.wr_x, bus.wr_y, bus.wr_pixel);
    else n_pass++;
    tick();
    n_total++;
    if ({done, pix_count, bus.cmd_ready} !==
        {1'b1, 19'd1, 1'b0})
      $display("FAIL b2b_done1: got %b/%0d/%b want 1/1/0",
               done, pix_count, bus.cmd_ready);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.cmd_ready, busy} !== 2'b10)
      $display("FAIL b2b_idle: got %b want 10",
               {bus.cmd_ready, busy});
    else n_pass++;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    n_total++;
    if ({bus.wr_valid, bus.wr_x, bus.wr_y,
         bus.wr_pixel} !==
        {1'b1, 10'd3, 10'd2, 24'h123456})
      $display("FAIL b2b_second: got %b/%0d/%0d/%h want 1/3/2/123456",
               bus.wr_valid, bus.wr_x,
               bus.wr_y, bus.wr_pixel);
    else n_pass++;
    tick();
    n_total++;
    if ({done, pix_count} !== {1'b1, 19'd1})
      $display("FAIL b2b_done2: got %b/%0d want 1/1",
               done, pix_count);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    bus.wr_ready = 1'b1;
    send_cmd(0, 0, 9, 9, 24'h555555);
    tick();
    tick();
    tick();
    n_total++;
    if (bus.wr_valid !== 1'b1)
      $display("FAIL mid_fill: got %b want 1",
               bus.wr_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.wr_valid, busy, pix_count} !==
        {1'b0, 1'b0, 19'd0})
      $display("FAIL async_rst: got %b/%b/%0d want 0/0/0",
               bus.wr_valid, busy, pix_count);
    else n_pass++;
    tick();
    #2 rst_n = 1'b1;
    #1;
    n_total++;
    if (bus.cmd_ready !== 1'b0)
      $display("FAIL rel_rdy0: got %b want 0",
               bus.cmd_ready);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.cmd_ready, bus.wr_valid, busy}
        !== 3'b100)
      $display("FAIL rel_rdy1: got %b want 100",
               {bus.cmd_ready, bus.wr_valid, busy});
    else n_pass++;
    tick();
    n_total++;
    if ({bus.wr_valid, done} !== 2'b00)
      $display("FAIL discarded: got %b want 00",
               {bus.wr_valid, done});
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_corner();
    test_reject();
    test_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed",
             n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rect_fill_ctrl.md
RECT_FILL_CTRL -- requirements
Module: rect_fill_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640, horizontal active pixels; legal X is 0..H_ACTIVE-1.
REQ-002 Parameter V_ACTIVE, default 480, vertical active lines; legal Y is 0..V_ACTIVE-1.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  rectangle command present.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  10 each  inclusive rectangle corners.
REQ-009 cmd_color  in  24  RGB888 fill colour.
REQ-010 abort  in  1  synchronous request to stop the current fill.
REQ-011 wr_valid  out  1  pixel write request to the framebuffer/pixel sink.
REQ-012 wr_ready  in  1  sink accepts the write.
REQ-013 wr_x, wr_y  out  10 each  pixel coordinate.
REQ-014 wr_pixel  out  24  pixel colour.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse: rectangle completed.
REQ-017 err  out  1  one-cycle pulse: command rejected.
REQ-018 pix_count  out  19  pixels written for the current or last command.

Function
REQ-019 FSM states SHALL be IDLE, CHECK, FILL and FINISH; all outputs are registered.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready, which latches all cmd_* fields, clears pix_count and moves the FSM to CHECK.
REQ-021 CHECK SHALL last one cycle and reject the command if x0>x1, y0>y1, x1>=H_ACTIVE or y1>=V_ACTIVE: err pulses, the FSM returns to IDLE and no write is issued.
REQ-022 For a legal command, CHECK SHALL load wr_x=x0, wr_y=y0 and wr_pixel=color and enter FILL, so wr_valid first asserts two cycles after the accept cycle.
REQ-023 In FILL, wr_valid SHALL stay 1, and wr_x, wr_y and wr_pixel SHALL hold stable while wr_ready=0.
REQ-024 Each handshake (wr_valid&&wr_ready) SHALL increment pix_count and advance row-major: wr_x+1, or when wr_x==x1, set wr_x=x0 and wr_y+1.
REQ-025 The handshake at (x1,y1) SHALL drop wr_valid on the next cycle and enter FINISH; FINISH pulses done for exactly one cycle and then returns to IDLE.
REQ-026 pix_count SHALL equal (x1-x0+1)*(y1-y0+1) when done pulses and SHALL hold until the next accept; the maximum is 307200, which fits in 19 bits.
REQ-027 A single-pixel rectangle (x0==x1, y0==y1) SHALL produce exactly one write and then done.
REQ-028 abort=1 in FILL SHALL return the FSM to IDLE on the next cycle with wr_valid=0 and without a done or err pulse; a handshake in the same cycle still counts in pix_count.
REQ-029 abort SHALL be ignored in IDLE, CHECK and FINISH.
REQ-030 cmd_valid outside IDLE SHALL be ignored; the command is not lost, because cmd_ready=0 stalls the source.
REQ-031 After done, err or abort, cmd_ready SHALL be 1 in the following cycle (IDLE), so the minimum command-to-command spacing is accept, CHECK, FILL..., FINISH, IDLE.

Reset
REQ-032 While rst_n=0, all state SHALL be held at reset values: FSM=IDLE; cmd_ready, wr_valid, busy, done and err =0; wr_x, wr_y, wr_pixel and pix_count =0.
REQ-033 cmd_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-034 Reset asserted mid-FILL SHALL clear wr_valid immediately, without waiting for a clock, and SHALL discard the command.

Verification
REQ-035 Command (2,3)-(4,4), colour 0xFF0000, with wr_ready=1 -> writes (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), each with wr_pixel=0xFF0000; done pulses once; pix_count=6.
REQ-036 Command (0,0)-(639,479), colour 0x00FF00, with wr_ready=1 -> 307200 writes, last at (639,479); done; pix_count=307200.
REQ-037 Commands (5,0)-(4,0) and (0,0)-(640,0) -> err pulses two cycles after accept for each; no wr_valid; pix_count=0.
REQ-038 Command (10,10)-(11,10) with wr_ready toggling 0,1,0,0,1 -> wr_x/wr_y held steady while stalled; exactly 2 writes; done.
REQ-039 Command (0,0)-(9,0), abort asserted together with the 4th handshake -> wr_valid=0 on the next cycle; pix_count=4; no done; cmd_ready=1.
REQ-040 rst_n pulsed low mid-FILL of (0,0)-(9,9) -> wr_valid and busy go 0 asynchronously; cmd_ready=1 after the first clock edge following release.
